md_issue_ctrl: RTL and testbench



---
 rtl/md_pkg.sv | 35 +++
 rtl/md_countdown.sv | 41 ++++
 rtl/md_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_md_issue_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared multiply/divide op encodings and latency defaults
//
// Purpose: op enum shared by the decoder, md_issue_ctrl and the MD datapath,
// controller state enum, default busy-cycle counts and op-class helpers.
// Ports: none (package).
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_countdown.sv
// rtl/md_countdown.sv - loadable down-counter for MD operation latency
//
// Purpose: holds the busy cycles left for the operation in flight.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous active-low reset (count -> 0)
//   load     in  load load_val this edge (wins over dec)
//   load_val in  value to load
//   dec      in  decrement this edge (saturates at 0)
//   count    out current count
//   is_one   out count == 1
//   is_zero  out count == 0
module md_countdown #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             is_one,
  output logic             is_zero
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !is_zero) begin
      count <= count - ONE;
    end
  end

  assign is_one  = (count == ONE);
  assign is_zero = (count == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - issue/latency/commit sequencer for the MD unit
//
// Purpose: launches E-stage mult/div/mthi/mtlo on the HI/LO datapath, counts
// the fixed latency, signals the HI/LO commit and stalls HI/LO users in D.
// Ports:
//   clk       in  clock, rising edge
//   reset     in  asynchronous active-low reset
//   e_valid   in  E-stage instruction valid
//   e_md_op   in  E-stage MD op (md_op_e)
//   req       in  exception/interrupt request; cancels this cycle's issue
//   d_uses_md in  D-stage instruction touches the MD unit / HI / LO
//   md_go     out one-cycle start pulse for mult/div
//   md_op     out op accompanying md_go / md_wr_* / the in-flight operation
//   md_wr_hi  out write rs into HI this edge (mthi)
//   md_wr_lo  out write rs into LO this edge (mtlo)
//   md_commit out write result into HI/LO this edge
//   busy      out operation in flight
//   remaining out busy cycles left including the current one
//   stall     out hold F/D, bubble into E
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_valid,
  input  logic [2:0]       e_md_op,
  input  logic             req,
  input  logic             d_uses_md,
  output logic             md_go,
  output logic [2:0]       md_op,
  output logic             md_wr_hi,
  output logic             md_wr_lo,
  output logic             md_commit,
  output logic             busy,
  output logic [CNT_W-1:0] remaining,
  output logic             stall
);

  localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

  md_state_e        state_q, state_d;
  logic [2:0]       op_q;
  logic             issue;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_is_one;
  logic             cnt_is_zero;

  md_countdown #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .is_one   (cnt_is_one),
    .is_zero  (cnt_is_zero)
  );

  // Gating with reset keeps every output quiet while reset is held, even if
  // the pipeline still presents a valid op in E.
  assign issue = reset & e_valid & ~req & (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= MD_NONE;
    end else begin
      state_q <= state_d;
      if (md_go) begin
        op_q <= e_md_op;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    md_go     = 1'b0;
    md_wr_hi  = 1'b0;
    md_wr_lo  = 1'b0;
    md_commit = 1'b0;
    md_op     = MD_NONE;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    cnt_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          if (op_is_mul(e_md_op)) begin
            md_go    = 1'b1;
            md_op    = e_md_op;
            cnt_load = 1'b1;
            cnt_val  = MULT_LD;
            state_d  = ST_MUL;
          end else if (op_is_div(e_md_op)) begin
            md_go    = 1'b1;
            md_op    = e_md_op;
            cnt_load = 1'b1;
            cnt_val  = DIV_LD;
            state_d  = ST_DIV;
          end else if (e_md_op == MD_MTHI) begin
            md_wr_hi = 1'b1;
            md_op    = e_md_op;
          end else if (e_md_op == MD_MTLO) begin
            md_wr_lo = 1'b1;
            md_op    = e_md_op;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        // Ops arriving in E here are ignored; the pipeline stall prevents them.
        cnt_dec = 1'b1;
        md_op   = op_q;
        if (cnt_is_one) begin
          md_commit = 1'b1;
          state_d   = ST_IDLE;
        end else if (cnt_is_zero) begin
          // A spent counter in a busy state cannot occur; recover to IDLE
          // without committing anything.
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign remaining = busy ? cnt : '0;
  assign stall     = d_uses_md & (busy | md_go);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb/tb_md_issue_ctrl.sv - self-checking bench for md_issue_ctrl
module tb_md_issue_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam int CW     = 4;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic          clk = 1'b0;
  logic          reset;
  logic          e_valid;
  logic [2:0]    e_md_op;
  logic          req;
  logic          d_uses_md;
  logic          md_go;
  logic [2:0]    md_op;
  logic          md_wr_hi;
  logic          md_wr_lo;
  logic          md_commit;
  logic          busy;
  logic [CW-1:0] remaining;
  logic          stall;

  int checks = 0;
  int errors = 0;

  // Reference model: the in-flight operation is described only by the cycle
  // it was launched and the cycle it commits.
  int         cyc       = 0;
  int         go_at     = -100;
  int         commit_at = -100;
  logic [2:0] cur_op    = 3'd0;

  always #5 clk = ~clk;

  md_issue_ctrl #(
    .MULT_CYCLES (MULT_N),
    .DIV_CYCLES  (DIV_N),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_md_op   (e_md_op),
    .req       (req),
    .d_uses_md (d_uses_md),
    .md_go     (md_go),
    .md_op     (md_op),
    .md_wr_hi  (md_wr_hi),
    .md_wr_lo  (md_wr_lo),
    .md_commit (md_commit),
    .busy      (busy),
    .remaining (remaining),
    .stall     (stall)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, compare every output
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic v, input logic [2:0] op, input logic rq,
                      input logic d, input logic rst);
    bit inflight, iss, is_md, x_go, x_whi, x_wlo, x_commit, x_stall;
    int x_rem, x_op, lat;
    @(negedge clk);
    e_valid   = v;
    e_md_op   = op;
    req       = rq;
    d_uses_md = d;
    reset     = rst;
    if (!rst) begin
      go_at     = -100;
      commit_at = -100;
    end
    #1;
    inflight = rst && (cyc > go_at) && (cyc <= commit_at);
    iss      = rst && v && !rq && !inflight;
    is_md    = (op >= OP_MULT) && (op <= OP_DIVU);
    x_go     = iss && is_md;
    x_whi    = iss && (op == OP_MTHI);
    x_wlo    = iss && (op == OP_MTLO);
    x_commit = inflight && (cyc == commit_at);
    x_rem    = inflight ? (commit_at - cyc + 1) : 0;
    x_op     = (x_go || x_whi || x_wlo) ? int'(op) : (inflight ? int'(cur_op) : 0);
    x_stall  = d && (inflight || x_go);
    check("md_go",     int'(md_go),     int'(x_go));
    check("md_wr_hi",  int'(md_wr_hi),  int'(x_whi));
    check("md_wr_lo",  int'(md_wr_lo),  int'(x_wlo));
    check("md_commit", int'(md_commit), int'(x_commit));
    check("busy",      int'(busy),      int'(inflight));
    check("remaining", int'(remaining), x_rem);
    check("md_op",     int'(md_op),     x_op);
    check("stall",     int'(stall),     int'(x_stall));
    @(posedge clk);
    if (x_go) begin
      lat       = (op == OP_MULT || op == OP_MULTU) ? MULT_N : DIV_N;
      go_at     = cyc;
      commit_at = cyc + lat;
      cur_op    = op;
    end
    cyc++;
  endtask

  task automatic idle_cycles(input int n, input logic d);
    for (int i = 0; i < n; i++) step(1'b0, OP_NONE, 1'b0, d, 1'b1);
  endtask

  initial begin
    reset     = 1'b0;
    e_valid   = 1'b0;
    e_md_op   = OP_NONE;
    req       = 1'b0;
    d_uses_md = 1'b0;

    // Held in reset with a valid op presented: everything stays quiet.
    step(1'b1, OP_MULT, 1'b0, 1'b1, 1'b0);
    step(1'b0, OP_NONE, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);

    // MULT with an HI/LO user waiting in D.
    step(1'b1, OP_MULT, 1'b0, 1'b1, 1'b1);
    idle_cycles(6, 1'b1);

    // DIVU then MULTU back-to-back.
    step(1'b1, OP_DIVU, 1'b0, 1'b1, 1'b1);
    idle_cycles(10, 1'b1);
    step(1'b1, OP_MULTU, 1'b0, 1'b1, 1'b1);
    idle_cycles(6, 1'b0);

    // mtlo / mthi, with and without a cancelling request.
    step(1'b1, OP_MTLO, 1'b0, 1'b0, 1'b1);
    step(1'b1, OP_MTLO, 1'b1, 1'b0, 1'b1);
    step(1'b1, OP_MTHI, 1'b0, 1'b1, 1'b1);
    idle_cycles(1, 1'b0);

    // DIV cancelled in its issue cycle, then a DIV with req mid-flight.
    step(1'b1, OP_DIV, 1'b1, 1'b0, 1'b1);
    idle_cycles(2, 1'b0);
    step(1'b1, OP_DIV, 1'b0, 1'b0, 1'b1);
    idle_cycles(2, 1'b0);
    step(1'b0, OP_NONE, 1'b1, 1'b0, 1'b1);
    idle_cycles(8, 1'b0);

    // Reset mid-MULT, then a fresh MULT.
    step(1'b1, OP_MULT, 1'b0, 1'b1, 1'b1);
    idle_cycles(2, 1'b1);
    step(1'b0, OP_NONE, 1'b0, 1'b1, 1'b0);
    step(1'b0, OP_NONE, 1'b0, 1'b1, 1'b0);
    step(1'b1, OP_MULT, 1'b0, 1'b1, 1'b1);
    idle_cycles(6, 1'b1);

    // Forced MULT while a DIV is in flight must be ignored.
    step(1'b1, OP_DIV, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, OP_MULT, 1'b0, 1'b1, 1'b1);
    idle_cycles(8, 1'b0);

    // Randomised traffic, including illegal op code 7 and rare resets.
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 63) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
